// File: rtl/aes_pkg.sv
// Shared types and constants for the AES accelerator SPI front-end.
// Frame layout on the wire is {text[127:0], key[K-1:0], dirbyte[7:0]}, MSB first.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT_IN,
      ST_WAIT,
      ST_SHIFT_OUT
   } spi_state_t;

   localparam logic DIR_DECRYPT = 1'b1;
   localparam int   RESULT_W    = 128;

   function automatic int frame_bits(input int k);
      return k + 136;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level and its previous value.
module spi_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_din,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_din;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI slave front-end: deserializes {text, key, dirbyte}, launches the AES core,
// then serializes the 128-bit result back on sdo.
//
//   state        | meaning
//   ST_IDLE      | waiting for a load rise
//   ST_SHIFT_IN  | shifting frame bits on sck rise; load fall ends the frame
//   ST_WAIT      | start issued, waiting for core_done
//   ST_SHIFT_OUT | done high, result shifted out on sck fall
module aes_spi_frontend #(
   parameter int K = 256
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_sck,
   input  logic           i_sdi,
   input  logic           i_load,
   output logic           o_sdo,
   output logic           o_done,
   output logic [K-1:0]   o_key,
   output logic [127:0]   o_text,
   output logic           o_dir,
   output logic           o_start,
   input  logic           i_core_done,
   input  logic [127:0]   i_core_result
);
   import aes_pkg::*;

   localparam int FRAME = frame_bits(K);
   localparam int CW    = $clog2(FRAME + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
   localparam logic [CW-1:0] CNT_OVR  = CW'(FRAME + 1);

   logic w_sck_rise, w_sck_fall, w_load_rise, w_load_fall;
   logic r_sdi_meta, r_sdi_sync;

   spi_sync u_sck_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_din   (i_sck),
      .o_rise  (w_sck_rise),
      .o_fall  (w_sck_fall)
   );

   spi_sync u_load_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_din   (i_load),
      .o_rise  (w_load_rise),
      .o_fall  (w_load_fall)
   );

   spi_state_t              r_state, w_next;
   logic [FRAME-1:0]        r_frame, w_frame_nxt;
   logic [CW-1:0]           r_cnt, w_cnt_nxt;
   logic [RESULT_W-1:0]     r_out;
   logic [6:0]              r_ocnt;
   logic [K-1:0]            r_key;
   logic [127:0]            r_text;
   logic                    r_dir, r_start, r_done;
   logic                    w_accept, w_capture;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sdi_meta <= 1'b0;
         r_sdi_sync <= 1'b0;
      end else begin
         r_sdi_meta <= i_sdi;
         r_sdi_sync <= r_sdi_meta;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // An sck edge coinciding with the load fall is folded in before the length check.
   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_frame_nxt = r_frame;
      w_cnt_nxt   = r_cnt;
      if (w_sck_rise) begin
         w_frame_nxt = {r_frame[FRAME-2:0], r_sdi_sync};
         if (r_cnt != CNT_OVR) w_cnt_nxt = r_cnt + 1'b1;
      end
      case (r_state)
         ST_IDLE: begin
            if (w_load_rise) w_next = ST_SHIFT_IN;
         end
         ST_SHIFT_IN: begin
            if (w_load_fall) begin
               if (w_cnt_nxt == CNT_FULL) begin
                  w_accept = 1'b1;
                  w_next   = ST_WAIT;
               end else begin
                  w_next   = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            if (w_load_rise) begin
               w_next = ST_SHIFT_IN;
            end else if (i_core_done) begin
               w_capture = 1'b1;
               w_next    = ST_SHIFT_OUT;
            end
         end
         ST_SHIFT_OUT: begin
            if (w_load_rise)                           w_next = ST_SHIFT_IN;
            else if (w_sck_fall && r_ocnt == 7'd127)   w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_frame <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
         r_ocnt  <= '0;
         r_key   <= '0;
         r_text  <= '0;
         r_dir   <= 1'b0;
         r_start <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_start <= w_accept;
         r_done  <= (w_next == ST_SHIFT_OUT);
         if (w_next == ST_SHIFT_IN && r_state != ST_SHIFT_IN) begin
            r_cnt <= '0;
         end else if (r_state == ST_SHIFT_IN) begin
            r_cnt   <= w_cnt_nxt;
            r_frame <= w_frame_nxt;
         end
         if (w_accept) begin
            r_text <= w_frame_nxt[FRAME-1 -: 128];
            r_key  <= w_frame_nxt[K+7:8];
            r_dir  <= (|w_frame_nxt[7:0]) ? DIR_DECRYPT : ~DIR_DECRYPT;
         end
         if (w_capture) begin
            r_out  <= i_core_result;
            r_ocnt <= '0;
         end else if (r_state == ST_SHIFT_OUT && w_sck_fall) begin
            r_out  <= {r_out[RESULT_W-2:0], 1'b0};
            r_ocnt <= r_ocnt + 1'b1;
         end
      end
   end

   assign o_sdo   = r_out[RESULT_W-1];
   assign o_done  = r_done;
   assign o_key   = r_key;
   assign o_text  = r_text;
   assign o_dir   = r_dir;
   assign o_start = r_start;

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Bench driving a K=128 and a K=256 front-end from the same SPI pins; each frame
// is a valid length for at most one of them, the other must discard it.
module tb_aes_spi_frontend;

   logic         clk = 1'b0;
   logic         reset, sck, sdi, load, core_done;
   logic [127:0] core_result;

   logic         sdo0, done0, dir0, start0;
   logic [127:0] key0, text0;
   logic         sdo1, done1, dir1, start1;
   logic [255:0] key1;
   logic [127:0] text1;

   always #5 clk = ~clk;

   aes_spi_frontend #(.K(128)) u_dut128 (
      .i_clk(clk), .i_reset(reset), .i_sck(sck), .i_sdi(sdi), .i_load(load),
      .o_sdo(sdo0), .o_done(done0), .o_key(key0), .o_text(text0), .o_dir(dir0),
      .o_start(start0), .i_core_done(core_done), .i_core_result(core_result)
   );

   aes_spi_frontend #(.K(256)) u_dut256 (
      .i_clk(clk), .i_reset(reset), .i_sck(sck), .i_sdi(sdi), .i_load(load),
      .o_sdo(sdo1), .o_done(done1), .o_key(key1), .o_text(text1), .o_dir(dir1),
      .o_start(start1), .i_core_done(core_done), .i_core_result(core_result)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [255:0] exp_key  [2];
   logic [127:0] exp_text [2];
   logic         exp_dir  [2];
   int           exp_starts [2];

   int start_cnt0 = 0, start_cnt1 = 0, long_pulse = 0;
   logic prev_start0 = 1'b0, prev_start1 = 1'b0;

   always @(negedge clk) begin
      if (start0 === 1'b1) begin
         start_cnt0++;
         if (prev_start0 === 1'b1) long_pulse++;
      end
      if (start1 === 1'b1) begin
         start_cnt1++;
         if (prev_start1 === 1'b1) long_pulse++;
      end
      prev_start0 = start0;
      prev_start1 = start1;
   end

   function automatic int kof(input int d);
      return (d != 0) ? 256 : 128;
   endfunction

   function automatic logic [255:0] get_key(input int d);
      return (d != 0) ? key1 : {128'b0, key0};
   endfunction
   function automatic logic [255:0] get_text(input int d);
      return (d != 0) ? {128'b0, text1} : {128'b0, text0};
   endfunction
   function automatic logic [255:0] get_bit(input int d, input int which);
      logic b;
      case (which)
         0:       b = (d != 0) ? sdo1   : sdo0;
         1:       b = (d != 0) ? done1  : done0;
         2:       b = (d != 0) ? dir1   : dir0;
         default: b = (d != 0) ? start1 : start0;
      endcase
      return {255'b0, b};
   endfunction

   function automatic logic [399:0] build(input int k, input logic [127:0] t,
                                          input logic [255:0] key, input logic [7:0] db);
      logic [399:0] f;
      f = {272'b0, t};
      f = (f << k) | ({144'b0, key} & ((400'd1 << k) - 400'd1));
      f = (f << 8) | {392'b0, db};
      return f;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_held(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_k%0d_key", tag, kof(d)), get_key(d), exp_key[d]);
         chk($sformatf("%s_k%0d_text", tag, kof(d)), get_text(d), {128'b0, exp_text[d]});
         chk($sformatf("%s_k%0d_dir", tag, kof(d)), get_bit(d, 2), {255'b0, exp_dir[d]});
      end
   endtask

   task automatic check_reset_vals(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_k%0d_sdo", tag, kof(d)), get_bit(d, 0), 256'd0);
         chk($sformatf("%s_k%0d_done", tag, kof(d)), get_bit(d, 1), 256'd0);
         chk($sformatf("%s_k%0d_start", tag, kof(d)), get_bit(d, 3), 256'd0);
      end
      check_held(tag);
   endtask

   // Shifts nbits of 'bits' MSB first; rst_at >= 0 pulses reset after that many bits.
   task automatic send_frame(input int nbits, input logic [399:0] bits, input int rst_at);
      load = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            reset = 1'b1;
            load  = 1'b0;
            sck   = 1'b0;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
               exp_key[d]  = '0;
               exp_text[d] = '0;
               exp_dir[d]  = 1'b0;
            end
            check_reset_vals("mid_reset");
            reset = 1'b0;
            repeat (4) @(negedge clk);
            return;
         end
         sdi = bits[nbits-1-i];
         repeat (4) @(negedge clk);
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
      repeat (4) @(negedge clk);
      load = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int nbits, input logic [399:0] bits,
                            input logic [127:0] t, input logic [255:0] k,
                            input logic [7:0] db, output int acc);
      logic accd [2];
      send_frame(nbits, bits, -1);
      acc = -1;
      for (int d = 0; d < 2; d++) begin
         accd[d] = (nbits == kof(d) + 136);
         if (accd[d]) begin
            exp_text[d] = t;
            exp_key[d]  = (d != 0) ? k : {128'b0, k[127:0]};
            exp_dir[d]  = (db != 8'h00);
            exp_starts[d]++;
            acc = d;
         end
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++)
         chk($sformatf("%s_k%0d_start", tag, kof(d)), get_bit(d, 3), {255'b0, accd[d]});
      check_held(tag);
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         chk($sformatf("%s_k%0d_start_width", tag, kof(d)), get_bit(d, 3), 256'd0);
   endtask

   task automatic core_and_read(input string tag, input int d, input logic [127:0] res,
                                input int nread);
      logic [127:0] got;
      @(negedge clk);
      chk({tag, "_done_before"}, get_bit(d, 1), 256'd0);
      core_done   = 1'b1;
      core_result = res;
      @(negedge clk);
      core_done   = 1'b0;
      core_result = rand128();
      chk({tag, "_done_set"}, get_bit(d, 1), 256'd1);
      chk({tag, "_sdo_first"}, get_bit(d, 0), {255'b0, res[127]});
      got = '0;
      for (int i = 0; i < nread; i++) begin
         got = {got[126:0], get_bit(d, 0) == 256'd1};
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
         repeat (4) @(negedge clk);
      end
      if (nread == 128) begin
         chk({tag, "_readback"}, {128'b0, got}, {128'b0, res});
         chk({tag, "_done_end"}, get_bit(d, 1), 256'd0);
      end else begin
         chk({tag, "_partial"}, {128'b0, got}, {128'b0, res >> (128 - nread)});
      end
   endtask

   initial begin
      logic [127:0] t, r;
      logic [255:0] k;
      logic [399:0] f;
      logic [7:0]   db;
      int           acc, pick;

      reset = 1'b1; sck = 1'b0; sdi = 1'b0; load = 1'b0;
      core_done = 1'b0; core_result = '0;
      for (int d = 0; d < 2; d++) begin
         exp_key[d] = '0; exp_text[d] = '0; exp_dir[d] = 1'b0; exp_starts[d] = 0;
      end
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;
      repeat (3) @(negedge clk);

      t = 128'h3243F6A8885A308D313198A2E0370734;
      k = {128'b0, 128'h2B7E151628AED2A6ABF7158809CF4F3C};
      run_frame("fips_k128", 264, build(128, t, k, 8'h00), t, k, 8'h00, acc);
      core_and_read("fips_out", 0, 128'h3925841D02DC09FBDC118597196A0B32, 128);

      t = 128'h00112233445566778899AABBCCDDEEFF;
      k = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
      run_frame("k256_dec", 392, build(256, t, k, 8'h01), t, k, 8'h01, acc);
      core_and_read("k256_out", 1, rand128(), 128);

      for (int j = 0; j < 400; j++) f[j] = 1'($urandom_range(0, 1));
      run_frame("short100", 100, f, '0, '0, 8'h00, acc);
      run_frame("overrun393", 393, f, '0, '0, 8'h00, acc);
      run_frame("overrun265", 265, f, '0, '0, 8'h00, acc);

      t = rand128();
      k = {rand128(), rand128()};
      send_frame(264, build(128, t, k, 8'h00), 50);
      t = rand128();
      k = {rand128(), rand128()};
      db = 8'h80;
      run_frame("after_reset", 264, build(128, t, k, db), t, k, db, acc);
      core_and_read("after_reset_out", 0, rand128(), 128);

      for (int n = 0; n < 4; n++) begin
         pick = int'($urandom_range(0, 1));
         t  = rand128();
         k  = {rand128(), rand128()};
         db = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 255));
         run_frame($sformatf("rand%0d", n), kof(pick) + 136, build(kof(pick), t, k, db),
                   t, k, db, acc);
         if (acc >= 0) core_and_read($sformatf("rand%0d_out", n), acc, rand128(), 128);
      end

      t = rand128();
      k = {rand128(), rand128()};
      run_frame("abort_src", 264, build(128, t, k, 8'h00), t, k, 8'h00, acc);
      core_and_read("abort_out", 0, rand128(), 40);
      load = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_done_fall", get_bit(0, 1), 256'd0);
      t = rand128();
      k = {rand128(), rand128()};
      run_frame("post_abort", 392, build(256, t, k, 8'h5A), t, k, 8'h5A, acc);
      core_and_read("post_abort_out", 1, rand128(), 128);

      repeat (4) @(negedge clk);
      chk("start_total_k128", 256'(start_cnt0), 256'(exp_starts[0]));
      chk("start_total_k256", 256'(start_cnt1), 256'(exp_starts[1]));
      chk("start_long_pulse", 256'(long_pulse), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
